// File: rtl/core_seq.sv
// core_seq -- run controller for the single-cycle core.
//
// Owns the start/done handshake, gates every architectural update through
// core_run_en, arbitrates data memory between the core and a host loader,
// detects end-of-program (halt opcode or PC limit) and counts executed cycles.
//
// Optional feature: define CORE_SEQ_WATCHDOG_EN to abort runs that reach
// WDOG_LIMIT executed cycles without halting (timeout = 1).
//
// Ports:
//   clk              in   clock, rising edge
//   reset            in   asynchronous active-low reset
//   start            in   level request to (re)launch the program
//   host_mem_req     in   host requests data-memory ownership
//   host_mem_gnt     out  host owns data memory
//   core_pc          in   current PC from inst_fetch
//   core_halt        in   decoded halt instruction from control
//   core_fetch_reset out  forces inst_fetch PC to 0
//   core_run_en      out  qualifies PC advance, register and memory writes
//   busy             out  high in LAUNCH or RUN
//   done             out  program finished
//   timeout          out  last run ended by watchdog
//   cycle_count      out  executed-cycle count of the current/last run
module core_seq #(
    parameter int PC_WIDTH   = 11,
    parameter int HALT_PC    = 78,
    parameter int CYC_WIDTH  = 16,
    parameter int WDOG_LIMIT = 4095
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 host_mem_req,
    output logic                 host_mem_gnt,
    input  logic [PC_WIDTH-1:0]  core_pc,
    input  logic                 core_halt,
    output logic                 core_fetch_reset,
    output logic                 core_run_en,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic [CYC_WIDTH-1:0] cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LAUNCH,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [PC_WIDTH-1:0]  HALT_PC_W = PC_WIDTH'(HALT_PC);
    localparam logic [CYC_WIDTH-1:0] WDOG_CNT  = CYC_WIDTH'(WDOG_LIMIT);

`ifdef CORE_SEQ_WATCHDOG_EN
    localparam logic WDOG_ON = 1'b1;
`else
    localparam logic WDOG_ON = 1'b0;
`endif

    state_t state;
    logic   halt_cond;
    logic   wdog_hit;

    assign halt_cond = core_halt || (core_pc >= HALT_PC_W);

    // A genuine halt wins over the watchdog, so timeout only flags runaways.
    assign wdog_hit = WDOG_ON && (state == S_RUN) && !halt_cond &&
                      (cycle_count >= WDOG_CNT);

    // Combinational so the halting instruction itself never commits.
    assign core_run_en = (state == S_RUN) && !halt_cond && !wdog_hit;

    // All outputs other than core_run_en are set on the transition edge,
    // so they are Moore outputs of the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= S_IDLE;
            host_mem_gnt     <= 1'b0;
            core_fetch_reset <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            timeout          <= 1'b0;
            cycle_count      <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (host_mem_req) begin
                        // Leaving DONE for LOAD keeps cycle_count and timeout.
                        state        <= S_LOAD;
                        host_mem_gnt <= 1'b1;
                        done         <= 1'b0;
                    end else if (start) begin
                        state            <= S_LAUNCH;
                        core_fetch_reset <= 1'b1;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                        timeout          <= 1'b0;
                        cycle_count      <= '0;
                    end
                end
                S_LOAD: begin
                    if (!host_mem_req) begin
                        state        <= S_IDLE;
                        host_mem_gnt <= 1'b0;
                    end
                end
                S_LAUNCH: begin
                    if (!start) begin
                        state            <= S_RUN;
                        core_fetch_reset <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (start) begin
                        // Restart beats halt; counting starts over.
                        state            <= S_LAUNCH;
                        core_fetch_reset <= 1'b1;
                        cycle_count      <= '0;
                    end else begin
                        if (core_run_en && (cycle_count != '1))
                            cycle_count <= cycle_count + 1'b1;
                        if (halt_cond || wdog_hit) begin
                            state   <= S_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            timeout <= wdog_hit;
                        end
                    end
                end
                default: begin
                    state            <= S_IDLE;
                    host_mem_gnt     <= 1'b0;
                    core_fetch_reset <= 1'b0;
                    busy             <= 1'b0;
                    done             <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_seq.sv
// tb_core_seq -- self-checking bench for core_seq.
// A small fetch model stands in for inst_fetch (PC cleared by fetch reset,
// advanced by run enable); expectations come from the program length, the
// chosen halt point and the launch hold time.
module tb_core_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        host_mem_req;
    logic        host_mem_gnt;
    logic [10:0] core_pc;
    logic        core_halt;
    logic        core_fetch_reset;
    logic        core_run_en;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [15:0] cycle_count;

    // second instance with a narrow counter for saturation
    logic        s_start;
    logic        s_gnt, s_fr, s_run, s_busy, s_done, s_tmo;
    logic [3:0]  s_cnt;
    logic [10:0] s_pc = 11'd3;

    logic        halt_en;
    logic [10:0] halt_at;
    logic        hold_pc;
    logic [10:0] pc_m;
    int          committed;
    int          frc = 0;
    int          errs = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    core_seq #(.PC_WIDTH(11), .HALT_PC(78), .CYC_WIDTH(16), .WDOG_LIMIT(100)) dut (
        .clk(clk), .reset(reset), .start(start), .host_mem_req(host_mem_req),
        .host_mem_gnt(host_mem_gnt), .core_pc(core_pc), .core_halt(core_halt),
        .core_fetch_reset(core_fetch_reset), .core_run_en(core_run_en),
        .busy(busy), .done(done), .timeout(timeout), .cycle_count(cycle_count)
    );

    core_seq #(.PC_WIDTH(11), .HALT_PC(78), .CYC_WIDTH(4), .WDOG_LIMIT(15)) dut_sat (
        .clk(clk), .reset(reset), .start(s_start), .host_mem_req(1'b0),
        .host_mem_gnt(s_gnt), .core_pc(s_pc), .core_halt(1'b0),
        .core_fetch_reset(s_fr), .core_run_en(s_run),
        .busy(s_busy), .done(s_done), .timeout(s_tmo), .cycle_count(s_cnt)
    );

    // fetch model
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_m      <= '0;
            committed <= 0;
        end else if (core_fetch_reset) begin
            pc_m      <= '0;
            committed <= 0;
        end else if (core_run_en) begin
            pc_m      <= pc_m + 11'd1;
            committed <= committed + 1;
        end
    end

    always @(posedge clk) if (core_fetch_reset) frc <= frc + 1;

    assign core_pc   = hold_pc ? 11'd3 : pc_m;
    assign core_halt = halt_en && (core_pc == halt_at);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // host and core must never both own memory
    always @(negedge clk) if (reset) chk("excl", 32'(host_mem_gnt & core_run_en), 0);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One program run: h < 78 halts by opcode at PC h, h = 78 by PC limit.
    // rs > 0 restarts at that count, rq >= 0 raises host request at that count.
    task automatic do_run(input int h, input int rs, input int rq);
        int L, f0;
        bit rsd, rqd, fin;
        L = $urandom_range(1, 3);
        halt_en = (h < 78);
        halt_at = 11'(h);
        rsd = 0; rqd = 0; fin = 0;
        f0 = frc;
        start = 1'b1;
        repeat (L) @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (done) begin fin = 1; break; end
            if (core_halt) chk("halt_blk", 32'(core_run_en), 0);
            if (rqd) chk("gnt_run", 32'(host_mem_gnt), 0);
            if (rq >= 0 && !rqd && cycle_count == 16'(rq)) begin
                host_mem_req = 1'b1;
                rqd = 1;
            end
            if (rs > 0 && !rsd && cycle_count == 16'(rs)) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                rsd = 1;
                chk("rs_cnt", 32'(cycle_count), 0);
                chk("rs_fr", 32'(core_fetch_reset), 1);
            end
        end
        chk("fin", 32'(fin), 1);
        chk("cnt", 32'(cycle_count), 32'(h));
        chk("cmt", 32'(committed), 32'(h));
        chk("busy_dn", 32'(busy), 0);
        chk("tmo_dn", 32'(timeout), 0);
        if (!rsd) chk("fr_len", 32'(frc - f0), 32'(L));
        if (rqd) begin
            chk("gnt_dn", 32'(host_mem_gnt), 0);
            tick();
            chk("gnt_ld", 32'(host_mem_gnt), 1);
            chk("done_ld", 32'(done), 0);
            chk("cnt_ld", 32'(cycle_count), 32'(h));
            host_mem_req = 1'b0;
            tick();
            chk("gnt_rel", 32'(host_mem_gnt), 0);
        end
    endtask

    initial begin
        int h, rs, rq;
        reset = 1'b0; start = 1'b0; host_mem_req = 1'b0; s_start = 1'b0;
        halt_en = 1'b0; halt_at = '0; hold_pc = 1'b0;
        #12;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_gnt", 32'(host_mem_gnt), 0);
        chk("rst_fr", 32'(core_fetch_reset), 0);
        chk("rst_cnt", 32'(cycle_count), 0);
        @(negedge clk) reset = 1'b1;
        repeat (3) tick();
        chk("idle_busy", 32'(busy), 0);
        chk("idle_run", 32'(core_run_en), 0);

        // simultaneous request and start in IDLE: host wins, start ignored
        host_mem_req = 1'b1; start = 1'b1;
        tick();
        chk("arb_gnt", 32'(host_mem_gnt), 1);
        chk("arb_busy", 32'(busy), 0);
        repeat (2) tick();
        chk("arb_gnt2", 32'(host_mem_gnt), 1);
        chk("arb_fr", 32'(core_fetch_reset), 0);
        host_mem_req = 1'b0; start = 1'b0;
        tick();
        chk("arb_rel", 32'(host_mem_gnt), 0);
        chk("arb_busy2", 32'(busy), 0);

        // directed runs
        do_run(78, -1, -1);
        do_run(5, -1, -1);
        do_run(78, 30, -1);
        do_run(40, -1, 10);
        do_run(0, -1, -1);

        // randomized runs
        for (int n = 0; n < 8; n++) begin
            h  = $urandom_range(0, 78);
            rs = (h > 2 && $urandom_range(0, 1) == 1) ? $urandom_range(1, h - 1) : -1;
            rq = (h > 1 && $urandom_range(0, 1) == 1) ? $urandom_range(0, h - 1) : -1;
            do_run(h, rs, rq);
        end

        // runaway program: PC stuck at 3
        halt_en = 1'b0; hold_pc = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (done) break;
        end
`ifdef CORE_SEQ_WATCHDOG_EN
        chk("wd_done", 32'(done), 1);
        chk("wd_tmo", 32'(timeout), 1);
        chk("wd_cnt", 32'(cycle_count), 100);
        chk("wd_cmt", 32'(committed), 100);
`else
        chk("wd_done", 32'(done), 0);
        chk("wd_tmo", 32'(timeout), 0);
        chk("wd_busy", 32'(busy), 1);
`endif
        hold_pc = 1'b0;
        do_run(78, -1, -1);

        // asynchronous reset in the middle of a run
        halt_en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        chk("mr_busy", 32'(busy), 1);
        #2 reset = 1'b0;
        #1;
        chk("mr_busy0", 32'(busy), 0);
        chk("mr_run0", 32'(core_run_en), 0);
        chk("mr_done0", 32'(done), 0);
        chk("mr_cnt0", 32'(cycle_count), 0);
        chk("mr_gnt0", 32'(host_mem_gnt), 0);
        chk("mr_fr0", 32'(core_fetch_reset), 0);
        @(negedge clk) reset = 1'b1;
        repeat (5) tick();
        chk("mr_idle", 32'(busy), 0);
        chk("mr_cnt", 32'(cycle_count), 0);

        // saturation of a 4-bit counter
        s_start = 1'b1;
        repeat (2) tick();
        s_start = 1'b0;
        repeat (25) tick();
        chk("sat_cnt", 32'(s_cnt), 15);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
